// File: rtl/systolic_pkg.sv
// Shared types and parameter defaults for the double-buffered weight-stationary systolic array.
package systolic_pkg;

  localparam int unsigned DefRows      = 4;
  localparam int unsigned DefCols      = 4;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAccWidth  = 32;
  localparam int unsigned LenWidth     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/systolic_array_db_if.sv
// Job control, shadow-weight load, activation stream and result stream of systolic_array_db.
interface systolic_array_db_if #(
  parameter int unsigned ROWS       = systolic_pkg::DefRows,
  parameter int unsigned COLS       = systolic_pkg::DefCols,
  parameter int unsigned DATA_WIDTH = systolic_pkg::DefDataWidth,
  parameter int unsigned ACC_WIDTH  = systolic_pkg::DefAccWidth
);
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                                start;
  logic [systolic_pkg::LenWidth-1:0]   cfg_len;
  logic                                cfg_signed;
  logic                                busy;
  logic                                done;
  logic                                wload_en;
  logic [ColW-1:0]                     wload_col;
  logic [ROWS*DATA_WIDTH-1:0]          wload_data;
  logic                                act_valid;
  logic [ROWS*DATA_WIDTH-1:0]          act_data;
  logic                                act_ready;
  logic                                result_valid;
  logic [COLS*ACC_WIDTH-1:0]           result_data;
  logic                                result_ready;

  modport master (
    output start, cfg_len, cfg_signed, wload_en, wload_col, wload_data,
    output act_valid, act_data, result_ready,
    input  busy, done, act_ready, result_valid, result_data
  );

  modport slave (
    input  start, cfg_len, cfg_signed, wload_en, wload_col, wload_data,
    input  act_valid, act_data, result_ready,
    output busy, done, act_ready, result_valid, result_data
  );

endinterface

// File: rtl/systolic_pe_en.sv
// Weight-stationary MAC cell: forwards activation right and partial sum down, both registered
// and frozen while en_i is low.
module systolic_pe_en import systolic_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] weight_i,
  input  logic [DATA_WIDTH-1:0] act_i,
  input  logic [ACC_WIDTH-1:0]  psum_i,
  output logic [DATA_WIDTH-1:0] act_o,
  output logic [ACC_WIDTH-1:0]  psum_o
);

  logic [ACC_WIDTH-1:0]  act_ext, weight_ext, prod;
  logic [DATA_WIDTH-1:0] act_q;
  logic [ACC_WIDTH-1:0]  psum_q;

  // Extending both operands to ACC_WIDTH first gives the product modulo 2^ACC_WIDTH directly.
  assign act_ext    = {{(ACC_WIDTH-DATA_WIDTH){signed_i & act_i[DATA_WIDTH-1]}}, act_i};
  assign weight_ext = {{(ACC_WIDTH-DATA_WIDTH){signed_i & weight_i[DATA_WIDTH-1]}}, weight_i};
  assign prod       = act_ext * weight_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q  <= '0;
      psum_q <= '0;
    end else if (en_i) begin
      act_q  <= act_i;
      psum_q <= psum_i + prod;
    end
  end

  assign act_o  = act_q;
  assign psum_o = psum_q;

endmodule

// File: rtl/systolic_array_db.sv
// Weight-stationary ROWSxCOLS systolic matrix-vector engine with shadow/active weight banks
// and a globally stalled skew -> array -> deskew pipeline.
module systolic_array_db import systolic_pkg::*; #(
  parameter int unsigned ROWS       = DefRows,
  parameter int unsigned COLS       = DefCols,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth
) (
  input  logic                clk,
  input  logic                rst,
  systolic_array_db_if.slave  bus
);

  logic [DATA_WIDTH-1:0] w_shadow_q [ROWS][COLS];
  logic [DATA_WIDTH-1:0] w_active_q [ROWS][COLS];
  state_e                state_q, state_d;
  logic [LenWidth-1:0]   len_q, len_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic                  signed_q, signed_d;
  logic [ROWS+COLS:0]    vld_q;
  logic                  stall, accept, res_fire, start_ok;

  logic [DATA_WIDTH-1:0] skew_out [ROWS];
  logic [DATA_WIDTH-1:0] act_pass [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  psum_pass [ROWS][COLS];
  logic [COLS*ACC_WIDTH-1:0] res_data;

  assign bus.result_valid = vld_q[ROWS+COLS];
  assign stall            = bus.result_valid && !bus.result_ready;
  assign bus.act_ready    = (state_q == StRun) && !stall;
  assign accept           = bus.act_valid && bus.act_ready;
  assign res_fire         = bus.result_valid && bus.result_ready;
  assign start_ok         = (state_q == StIdle) && bus.start;
  assign bus.busy         = (state_q != StIdle);
  assign bus.done         = (state_q == StDone);
  assign bus.result_data  = res_data;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    signed_d  = signed_q;
    in_cnt_d  = accept   ? in_cnt_q + 1'b1  : in_cnt_q;
    out_cnt_d = res_fire ? out_cnt_q + 1'b1 : out_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d     = bus.cfg_len;
          signed_d  = bus.cfg_signed;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (bus.cfg_len == '0) ? StDone : StRun;
        end
      end
      StRun:   if (accept && (in_cnt_q == len_q - 1'b1)) state_d = StDrain;
      StDrain: if (res_fire && (out_cnt_q == len_q - 1'b1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      signed_q  <= 1'b0;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      signed_q  <= signed_d;
      if (!stall) vld_q <= {vld_q[ROWS+COLS-1:0], accept};
    end
  end

  // Active bank takes the pre-edge shadow, so a same-cycle shadow write misses this job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_shadow_q[r][c] <= '0;
          w_active_q[r][c] <= '0;
        end
      end
    end else begin
      if (start_ok) w_active_q <= w_shadow_q;
      if (bus.wload_en) begin
        for (int r = 0; r < ROWS; r++) begin
          w_shadow_q[r][bus.wload_col] <= bus.wload_data[r*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Row r enters r+1 registers late; bubbles carry zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] sk_q [r+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sk_q[k] <= '0;
      end else if (!stall) begin
        sk_q[0] <= accept ? bus.act_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= r; k++) sk_q[k] <= sk_q[k-1];
      end
    end
    assign skew_out[r] = sk_q[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in;
      logic [ACC_WIDTH-1:0]  p_in;
      if (c == 0) begin : g_a_edge
        assign a_in = skew_out[r];
      end else begin : g_a_chain
        assign a_in = act_pass[r][c-1];
      end
      if (r == 0) begin : g_p_edge
        assign p_in = '0;
      end else begin : g_p_chain
        assign p_in = psum_pass[r-1][c];
      end
      systolic_pe_en #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .en_i     (!stall),
        .signed_i (signed_q),
        .weight_i (w_active_q[r][c]),
        .act_i    (a_in),
        .psum_i   (p_in),
        .act_o    (act_pass[r][c]),
        .psum_o   (psum_pass[r][c])
      );
    end
  end

  // Column c waits COLS-c registers (last one is the output register) to realign lanes.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    logic [ACC_WIDTH-1:0] dk_q [COLS-c];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < COLS - c; k++) dk_q[k] <= '0;
      end else if (!stall) begin
        dk_q[0] <= psum_pass[ROWS-1][c];
        for (int k = 1; k < COLS - c; k++) dk_q[k] <= dk_q[k-1];
      end
    end
    assign res_data[c*ACC_WIDTH +: ACC_WIDTH] = dk_q[COLS-1-c];
  end

endmodule

// File: doc/systolic_array_db.md
SYSTOLIC_ARRAY_DB -- requirements
Module: systolic_array_db

Interface
REQ-001 SHALL have parameter ROWS, default 4: activation lanes and weight rows (K dimension).
REQ-002 SHALL have parameter COLS, default 4: weight columns and result lanes (N dimension).
REQ-003 SHALL have parameters DATA_WIDTH, default 8, and ACC_WIDTH, default 32: operand and accumulator widths.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1: one-cycle job launch pulse.
REQ-007 SHALL have ports cfg_len (input, 16: activation vectors per job) and cfg_signed (input, 1: 1 = signed operands), both sampled when start is accepted.
REQ-008 SHALL have ports busy and done, output, 1 each: job in progress; one-cycle job-complete pulse.
REQ-009 SHALL have ports wload_en (input, 1), wload_col (input, $clog2(COLS)) and wload_data (input, ROWS*DATA_WIDTH): shadow weight column write, lane r = W[r][col].
REQ-010 SHALL have ports act_valid (input, 1), act_data (input, ROWS*DATA_WIDTH) and act_ready (output, 1): activation vector stream, lane r = A[m][r].
REQ-011 SHALL have ports result_valid (output, 1), result_data (output, COLS*ACC_WIDTH) and result_ready (input, 1): result vector stream, lane c = C[m][c].

Function
REQ-012 SHALL compute C[m][c] = sum over r of A[m][r]*W[r][c], producing exactly one result vector per accepted activation vector, in acceptance order.
REQ-013 SHALL hold two weight banks, shadow and active; wload_en writes the shadow bank only, in any state.
REQ-014 SHALL copy shadow to active on the edge that accepts start; a wload_en in that same cycle lands in shadow after the copy and is not used by the job.
REQ-015 SHALL implement states IDLE, RUN, DRAIN and DONE; start is accepted only in IDLE and is ignored in all other states.
REQ-016 SHALL transition IDLE->RUN on start with cfg_len>0, and IDLE->DONE on start with cfg_len==0 (weights still swap, no results).
REQ-017 SHALL transition RUN->DRAIN on the edge accepting the cfg_len-th vector, DRAIN->DONE on the edge the last result handshakes, and DONE->IDLE unconditionally.
REQ-018 SHALL assert busy in RUN, DRAIN and DONE, assert done only in DONE, and assert act_ready only in RUN while not stalled.
REQ-019 SHALL skew input row r by r cycles and deskew output column c by COLS-1-c cycles internally, so that result lanes of one vector appear together.
REQ-020 SHALL raise result_valid for a vector exactly ROWS+COLS edges after its accepting edge when no stall occurs.
REQ-021 SHALL treat result_valid && !result_ready as a stall: the whole pipeline, including skew/deskew registers, freezes and result_data stays stable until the handshake.
REQ-022 SHALL sign-extend (cfg_signed=1) or zero-extend (cfg_signed=0) operands and products to ACC_WIDTH, summing modulo 2^ACC_WIDTH.
REQ-023 SHALL accumulate each vector independently, with no carry-over between vectors or jobs.

Reset
REQ-024 SHALL, while rst is high, clear both weight banks, all pipeline registers, the counters and the state to IDLE, and drive busy, done, act_ready and result_valid to 0 and result_data to 0.
REQ-025 SHALL, on reset asserted mid-job, abort the job without a done pulse; the first job after release SHALL behave as from power-up.

Structure
REQ-026 SHALL place the state enumeration and parameter defaults in shared package systolic_pkg.
REQ-027 SHALL instantiate sub-module systolic_pe_en per cell: stationary active weight, pass-through activation, psum in/out, stall enable and signed-mode input.

Verification
REQ-028 SHALL cover: W = identity, cfg_len=2, A=[1,2,3,4],[5,6,7,8] -> results [1,2,3,4],[5,6,7,8]; first result_valid 8 edges after first accept; done after second handshake.
REQ-029 SHALL cover: all W=8'hFF, A=[1,2,3,4]; cfg_signed=1 -> every lane -10; cfg_signed=0 -> every lane 2550.
REQ-030 SHALL cover: cfg_len=8, result_ready low for 5 cycles mid-stream -> act_ready low while stalled, no loss or duplication, order preserved, result_data stable while stalled.
REQ-031 SHALL cover: load W1, start job1; load W2 during job1 RUN; start job2 -> job1 results use W1, job2 results use W2.
REQ-032 SHALL cover: rst pulse mid-RUN -> all outputs 0 and no done; then cfg_len=0 start -> done exactly one cycle after start, no result_valid.
